// File: rtl/ptp_tsq_pkg.sv
// Shared constants for the PTP timestamp-queue collector: register map,
// FSM encoding and tag geometry.
package ptp_tsq_pkg;

    localparam int TAGW       = 3;
    localparam int HEAD_WORDS = 4;

    localparam logic [7:0] ADDR_CTRL     = 8'h00;
    localparam logic [7:0] ADDR_STAT     = 8'h04;
    localparam logic [7:0] ADDR_IRQ_EN   = 8'h08;
    localparam logic [7:0] ADDR_POP      = 8'h0C;
    localparam logic [7:0] ADDR_HEAD_TAG = 8'h10;
    localparam logic [7:0] ADDR_HEAD0    = 8'h14;
    localparam logic [7:0] ADDR_HEAD1    = 8'h18;
    localparam logic [7:0] ADDR_HEAD2    = 8'h1C;
    localparam logic [7:0] ADDR_HEAD3    = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_CAPT = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

endpackage

// File: rtl/ptp_tsq_collector_if.sv
// 32-bit CPU register bus between the register master and the collector.
interface ptp_tsq_collector_if;
    logic        wr_in;
    logic        rd_in;
    logic [7:0]  addr_in;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (output wr_in, output rd_in, output addr_in, output data_in, input data_out);
    modport slave  (input wr_in, input rd_in, input addr_in, input data_in, output data_out);
endinterface

// File: rtl/ptp_tsq_fifo.sv
// Synchronous holding FIFO with flush; pointers carry one extra wrap bit so
// count = wr - rd distinguishes full from empty.
module ptp_tsq_fifo #(
    parameter int W     = 131,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_wr,
    input  logic [W-1:0]             i_wdata,
    input  logic                     i_rd,
    output logic [W-1:0]             o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_wr;
    logic         w_do_rd;

    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_full  = (o_count == (AW+1)'(DEPTH));
    assign o_empty = (o_count == '0);
    assign w_do_wr = i_wr & ~o_full;
    assign w_do_rd = i_rd & ~o_empty;
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; flush wins over any concurrent push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (w_do_wr && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/ptp_tsq_collector.sv
// N-channel TSU timestamp-queue collector: round-robin drains enabled queues
// into a tagged holding FIFO that the CPU reads over the register bus.
module ptp_tsq_collector
    import ptp_tsq_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int QDW   = 128,
    parameter int STW   = 8,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    ptp_tsq_collector_if.slave   bus,
    output logic [NCH-1:0]       q_rst_out,
    output logic [NCH-1:0]       q_rd_en_out,
    input  logic [NCH*STW-1:0]   q_stat_in,
    input  logic [NCH*QDW-1:0]   q_data_in,
    output logic                 irq_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = TAGW + QDW;

    logic [NCH-1:0]          r_ctrl;
    logic [1:0]              r_irq_en;
    state_t                  r_state;
    logic [TAGW-1:0]         r_ch;
    logic [TAGW-1:0]         r_rr;
    logic [NCH-1:0]          r_q_rd_en;
    logic [NCH-1:0]          r_q_rst;
    logic [31:0]             r_data_out;
    logic                    r_irq;

    logic                    w_flush;
    logic                    w_pop;
    logic [NCH-1:0]          w_req;
    logic [TAGW:0]           w_pick;
    logic                    w_fifo_wr;
    logic [FW-1:0]           w_fifo_wdata;
    logic [FW-1:0]           w_head;
    logic                    w_full;
    logic                    w_empty;
    logic [AW:0]             w_count;
    logic [HEAD_WORDS*32-1:0] w_head_pad;
    logic [31:0]             w_rdata;

    // First requester after rr, wrapping; scanned backwards so the nearest wins
    function automatic logic [TAGW:0] rr_pick(input logic [NCH-1:0] req, input logic [TAGW-1:0] rr);
        logic [TAGW:0] res;
        int            idx;
        res = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx = (int'(rr) + k) % NCH;
            if (req[idx]) res = {1'b1, TAGW'(idx)};
        end
        return res;
    endfunction

    assign w_flush      = bus.wr_in && (bus.addr_in == ADDR_CTRL) && bus.data_in[31];
    assign w_pop        = bus.wr_in && (bus.addr_in == ADDR_POP);
    assign w_pick       = rr_pick(w_req, r_rr);
    assign w_fifo_wr    = (r_state == ST_CAPT);
    assign w_fifo_wdata = {r_ch, q_data_in[int'(r_ch)*QDW +: QDW]};

    // Per-channel request: enabled and queue not empty
    always_comb begin
        w_req = '0;
        for (int i = 0; i < NCH; i++) begin
            w_req[i] = r_ctrl[i] & (|q_stat_in[i*STW +: STW]);
        end
    end

    ptp_tsq_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_flush),
        .i_wr    (w_fifo_wr),
        .i_wdata (w_fifo_wdata),
        .i_rd    (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Drain sequencer; a flush aborts any in-flight entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ch      <= '0;
            r_rr      <= TAGW'(NCH - 1);
            r_q_rd_en <= '0;
        end else if (w_flush) begin
            r_state   <= ST_IDLE;
            r_q_rd_en <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_full && w_pick[TAGW]) begin
                        r_ch      <= w_pick[TAGW-1:0];
                        r_rr      <= w_pick[TAGW-1:0];
                        r_q_rd_en <= NCH'(1) << w_pick[TAGW-1:0];
                        r_state   <= ST_POP;
                    end
                end
                ST_POP: begin
                    r_q_rd_en <= '0;
                    r_state   <= ST_CAPT;
                end
                ST_CAPT: r_state <= ST_GAP;
                ST_GAP:  r_state <= ST_IDLE;
                default: begin
                    r_q_rd_en <= '0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Head data zero-extended or truncated to the four readable words
    always_comb begin
        w_head_pad = '0;
        for (int b = 0; b < HEAD_WORDS*32; b++) begin
            if (b < QDW) w_head_pad[b] = w_head[b] & ~w_empty;
        end
    end

    // Register read mux
    always_comb begin
        case (bus.addr_in)
            ADDR_CTRL:     w_rdata = 32'(r_ctrl);
            ADDR_STAT:     w_rdata = {22'd0, w_full, w_empty, 8'(w_count)};
            ADDR_IRQ_EN:   w_rdata = {30'd0, r_irq_en};
            ADDR_HEAD_TAG: w_rdata = {~w_empty, 28'd0, w_head[FW-1 -: TAGW] & {TAGW{~w_empty}}};
            ADDR_HEAD0:    w_rdata = w_head_pad[31:0];
            ADDR_HEAD1:    w_rdata = w_head_pad[63:32];
            ADDR_HEAD2:    w_rdata = w_head_pad[95:64];
            ADDR_HEAD3:    w_rdata = w_head_pad[127:96];
            default:       w_rdata = 32'd0;
        endcase
    end

    // Control registers, read-data capture, queue-reset pulse and interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl     <= '0;
            r_irq_en   <= 2'b00;
            r_q_rst    <= '0;
            r_data_out <= 32'd0;
            r_irq      <= 1'b0;
        end else begin
            if (bus.wr_in && bus.addr_in == ADDR_CTRL)   r_ctrl   <= bus.data_in[NCH-1:0];
            if (bus.wr_in && bus.addr_in == ADDR_IRQ_EN) r_irq_en <= bus.data_in[1:0];
            if (bus.rd_in) r_data_out <= w_rdata;
            r_q_rst <= w_flush ? '1 : '0;
            r_irq   <= (r_irq_en[0] & ~w_empty) | (r_irq_en[1] & w_full);
        end
    end

    assign bus.data_out = r_data_out;
    assign q_rst_out    = r_q_rst;
    assign q_rd_en_out  = r_q_rd_en;
    assign irq_out      = r_irq;

endmodule

// File: tb/tb_ptp_tsq_collector.sv
// Directed bench for ptp_tsq_collector with a behavioural 4-channel TSU queue model.
module tb_ptp_tsq_collector;
    localparam int NCH = 4;
    localparam int QDW = 128;
    localparam int STW = 8;

    logic                 clk;
    logic                 rst;
    logic [NCH-1:0]       q_rst_out;
    logic [NCH-1:0]       q_rd_en_out;
    logic [NCH*STW-1:0]   q_stat_in;
    logic [NCH*QDW-1:0]   q_data_in;
    logic                 irq_out;

    ptp_tsq_collector_if bus ();

    ptp_tsq_collector #(.NCH(NCH), .QDW(QDW), .STW(STW), .DEPTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .q_rst_out   (q_rst_out),
        .q_rd_en_out (q_rd_en_out),
        .q_stat_in   (q_stat_in),
        .q_data_in   (q_data_in),
        .irq_out     (irq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // TSU queue model
    logic [STW-1:0] tb_stat [NCH];
    logic [QDW-1:0] tb_qd   [NCH];
    int             tb_seq  [NCH];
    logic           load_req = 1'b0;
    int             load_ch  = 0;
    logic [STW-1:0] load_val = '0;
    int             pop_log [32];
    int             pop_cnt;

    function automatic logic [QDW-1:0] mk(input int ch, input int seq);
        logic [31:0] w0;
        logic [31:0] w1;
        w0 = 32'h000000A5 | (32'(ch) << 8) | (32'(seq) << 16);
        w1 = 32'hC0DE0000 | 32'(ch);
        return {32'h0, 32'h0, w1, w0};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                tb_stat[i] <= '0;
                tb_qd[i]   <= '0;
                tb_seq[i]  <= 0;
            end
            pop_cnt <= 0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (q_rst_out[i]) tb_stat[i] <= '0;
                else if (load_req && load_ch == i) tb_stat[i] <= load_val;
                else if (q_rd_en_out[i] && tb_stat[i] != '0) begin
                    tb_stat[i] <= tb_stat[i] - 1'b1;
                    tb_qd[i]   <= mk(i, tb_seq[i]);
                    tb_seq[i]  <= tb_seq[i] + 1;
                end
                if (q_rd_en_out[i] && pop_cnt < 32) pop_log[pop_cnt] <= i;
            end
            if (q_rd_en_out != '0) pop_cnt <= pop_cnt + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            q_stat_in[i*STW +: STW] = tb_stat[i];
            q_data_in[i*QDW +: QDW] = tb_qd[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.wr_in = 1'b1; bus.addr_in = a; bus.data_in = d;
        @(negedge clk);
        bus.wr_in = 1'b0;
    endtask

    task automatic reg_rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.rd_in = 1'b1; bus.addr_in = a;
        @(negedge clk);
        bus.rd_in = 1'b0;
        d = bus.data_out;
    endtask

    task automatic load(input int ch, input logic [STW-1:0] v);
        @(negedge clk);
        load_req = 1'b1; load_ch = ch; load_val = v;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic wait_rd_en();
        for (int k = 0; k < 20 && q_rd_en_out == '0; k++) @(negedge clk);
    endtask

    logic [31:0] rv;
    int          snap;

    initial begin
        bus.wr_in = 1'b0; bus.rd_in = 1'b0; bus.addr_in = 8'h00; bus.data_in = 32'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_data_out", bus.data_out, 32'h0);
        chk("rst_irq", 32'(irq_out), 32'h0);
        chk("rst_rd_en", 32'(q_rd_en_out), 32'h0);
        chk("rst_q_rst", 32'(q_rst_out), 32'h0);
        reg_rd(8'h04, rv); chk("rst_stat", rv, 32'h00000100);

        // Single entry from ch1
        load(1, 8'd1);
        reg_wr(8'h00, 32'h3);
        wait_rd_en();
        chk("ch1_rd_en", 32'(q_rd_en_out), 32'h2);
        @(negedge clk);
        chk("ch1_rd_en_pulse", 32'(q_rd_en_out), 32'h0);
        repeat (4) @(negedge clk);
        reg_rd(8'h10, rv); chk("ch1_tag", rv, 32'h80000001);
        reg_rd(8'h14, rv); chk("ch1_word0", rv, 32'h000001A5);
        reg_rd(8'h18, rv); chk("ch1_word1", rv, 32'hC0DE0001);
        reg_rd(8'h04, rv); chk("ch1_stat", rv, 32'h00000001);
        reg_wr(8'h0C, 32'h0);
        reg_rd(8'h04, rv); chk("ch1_pop_stat", rv, 32'h00000100);

        // Round robin over four channels until the FIFO fills (rr now at ch1)
        reg_wr(8'h00, 32'h0);
        load(0, 8'd3); load(1, 8'd2); load(2, 8'd2); load(3, 8'd2);
        snap = pop_cnt;
        reg_wr(8'h00, 32'hF);
        repeat (60) @(negedge clk);
        chk("rr_count", 32'(pop_cnt - snap), 32'd8);
        for (int k = 0; k < 8; k++) chk($sformatf("rr_order%0d", k), 32'(pop_log[snap + k]), 32'((2 + k) % 4));
        reg_rd(8'h04, rv); chk("full_stat", rv, 32'h00000208);
        repeat (20) @(negedge clk);
        chk("full_no_pop", 32'(pop_cnt - snap), 32'd8);
        reg_rd(8'h10, rv); chk("full_tag", rv, 32'h80000002);
        reg_rd(8'h14, rv); chk("full_word0", rv, 32'h000002A5);
        reg_wr(8'h0C, 32'h0);
        repeat (10) @(negedge clk);
        chk("ninth_pop", 32'(pop_cnt - snap), 32'd9);
        chk("ninth_ch", 32'(pop_log[snap + 8]), 32'd0);
        reg_rd(8'h04, rv); chk("ninth_stat", rv, 32'h00000208);
        reg_rd(8'h10, rv); chk("ninth_head_tag", rv, 32'h80000003);

        // Flush of a full FIFO
        @(negedge clk);
        bus.wr_in = 1'b1; bus.addr_in = 8'h00; bus.data_in = 32'h8000000F;
        @(negedge clk);
        bus.wr_in = 1'b0;
        chk("flush_q_rst", 32'(q_rst_out), 32'hF);
        @(negedge clk);
        chk("flush_q_rst_end", 32'(q_rst_out), 32'h0);
        reg_rd(8'h04, rv); chk("flush_stat", rv, 32'h00000100);
        reg_rd(8'h00, rv); chk("flush_ctrl_kept", rv, 32'h0000000F);

        // Flush while the FSM is capturing
        load(3, 8'd1);
        wait_rd_en();
        chk("capt_rd_en", 32'(q_rd_en_out), 32'h8);
        @(negedge clk);
        bus.wr_in = 1'b1; bus.addr_in = 8'h00; bus.data_in = 32'h8000000F;
        @(negedge clk);
        bus.wr_in = 1'b0;
        chk("capt_q_rst", 32'(q_rst_out), 32'hF);
        repeat (5) @(negedge clk);
        reg_rd(8'h04, rv); chk("capt_stat", rv, 32'h00000100);
        reg_rd(8'h10, rv); chk("capt_tag", rv, 32'h00000000);

        // Not-empty interrupt
        reg_wr(8'h08, 32'h1);
        repeat (2) @(negedge clk);
        chk("irq_idle", 32'(irq_out), 32'h0);
        load(1, 8'd1);
        for (int k = 0; k < 20 && !irq_out; k++) @(negedge clk);
        chk("irq_rise", 32'(irq_out), 32'h1);
        reg_rd(8'h04, rv); chk("irq_stat", rv, 32'h00000001);
        reg_wr(8'h0C, 32'h0);
        chk("irq_hold", 32'(irq_out), 32'h1);
        @(negedge clk);
        chk("irq_fall", 32'(irq_out), 32'h0);

        // Disabled channel is skipped; POP on empty ignored
        reg_wr(8'h00, 32'h5);
        load(1, 8'd1);
        snap = pop_cnt;
        repeat (20) @(negedge clk);
        chk("disabled_no_pop", 32'(pop_cnt - snap), 32'd0);
        reg_wr(8'h0C, 32'h0);
        reg_rd(8'h04, rv); chk("empty_pop_stat", rv, 32'h00000100);

        // Simultaneous read and write returns the pre-write value
        @(negedge clk);
        bus.wr_in = 1'b1; bus.rd_in = 1'b1; bus.addr_in = 8'h00; bus.data_in = 32'hA;
        @(negedge clk);
        bus.wr_in = 1'b0; bus.rd_in = 1'b0;
        chk("rw_pre_value", bus.data_out, 32'h5);
        reg_rd(8'h00, rv); chk("rw_post_value", rv, 32'hA);
        reg_rd(8'h40, rv); chk("unmapped", rv, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
